// File: rtl/memory_stage_pkg.sv
// Shared CPU definitions for the memory stage: branch condition codes,
// memory FSM states and the captured execute-stage bundle.
package memory_stage_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned REG_W   = 4;
   localparam int unsigned FLAGS_W = 3;

   typedef enum logic [2:0] {
      BC_NE = 3'b000,
      BC_EQ = 3'b001,
      BC_GT = 3'b010,
      BC_LT = 3'b011,
      BC_GE = 3'b100,
      BC_LE = 3'b101,
      BC_VS = 3'b110,
      BC_AL = 3'b111
   } branch_cond_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   // Flags are ordered {N,Z,V}.
   typedef struct packed {
      logic [DATA_W-1:0]  alu_result;
      logic [FLAGS_W-1:0] flags;
      logic [REG_W-1:0]   rd;
      logic [DATA_W-1:0]  reg_rt;
      logic               mem_read_en;
      logic               mem_write_en;
      logic               reg_write_en;
      logic               reg_write_src;
      logic [2:0]         branch_cond;
      logic               branch;
   } ex_bundle_t;

endpackage

// File: rtl/memory_stage_branch_cond_eval.sv
// Evaluates a branch condition code against registered {N,Z,V} flags.
module branch_cond_eval
   import memory_stage_pkg::*;
(
   input  logic [2:0]         cond,
   input  logic [FLAGS_W-1:0] flags,
   output logic               cond_met
);

   logic n_flag;
   logic z_flag;
   logic v_flag;

   assign n_flag = flags[2];
   assign z_flag = flags[1];
   assign v_flag = flags[0];

   always_comb begin
      cond_met = 1'b0;
      case (branch_cond_e'(cond))
         BC_NE: cond_met = !z_flag;
         BC_EQ: cond_met = z_flag;
         BC_GT: cond_met = !z_flag && !n_flag;
         BC_LT: cond_met = n_flag;
         BC_GE: cond_met = z_flag || (!z_flag && !n_flag);
         BC_LE: cond_met = n_flag || z_flag;
         BC_VS: cond_met = v_flag;
         BC_AL: cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   end

endmodule

// File: rtl/memory_stage_dff.sv
// Generic enabled register cell with asynchronous active-low clear.
module dff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: data memory handshake, branch resolution and
// writeback selection, holding its stage registers while stalled.
module memory_stage
   import memory_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] e_alu_result,
   input  logic [2:0]  e_flags,
   input  logic [3:0]  e_rd,
   input  logic [15:0] e_reg_rt,
   input  logic        e_mem_read_en,
   input  logic        e_mem_write_en,
   input  logic        e_reg_write_en,
   input  logic        e_reg_write_src,
   input  logic [2:0]  e_branch_cond,
   input  logic        e_branch,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        stall,
   output logic        branch_taken,
   output logic [15:0] branch_target,
   output logic [3:0]  m_rd,
   output logic        m_reg_write_en,
   output logic [15:0] m_wb_data
);

   ex_bundle_t ex_d;
   ex_bundle_t ex_q;
   mem_state_e state;
   logic       op;
   logic       cond_met;
   logic       read_done;

   assign ex_d = '{
      alu_result:    e_alu_result,
      flags:         e_flags,
      rd:            e_rd,
      reg_rt:        e_reg_rt,
      mem_read_en:   e_mem_read_en,
      mem_write_en:  e_mem_write_en,
      reg_write_en:  e_reg_write_en,
      reg_write_src: e_reg_write_src,
      branch_cond:   e_branch_cond,
      branch:        e_branch
   };

   dff #(.WIDTH($bits(ex_bundle_t))) u_stage_regs (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!stall),
      .d     (ex_d),
      .q     (ex_q)
   );

   branch_cond_eval u_branch_cond_eval (
      .cond     (ex_q.branch_cond),
      .flags    (ex_q.flags),
      .cond_met (cond_met)
   );

   assign op = ex_q.mem_read_en || ex_q.mem_write_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (op && !mem_ack) state <= ST_WAIT;
            ST_WAIT: if (mem_ack)        state <= ST_IDLE;
            default:                     state <= ST_IDLE;
         endcase
      end
   end

   // Request is combinational so a zero-wait ack retires the access in the
   // cycle it is presented; ack with no request never reaches the FSM path.
   assign mem_req   = ((state == ST_IDLE) && op) || (state == ST_WAIT);
   assign mem_wr    = ex_q.mem_write_en;
   assign mem_addr  = ex_q.alu_result;
   assign mem_wdata = ex_q.reg_rt;
   assign stall     = mem_req && !mem_ack;

   assign read_done = mem_req && mem_ack && !ex_q.mem_write_en;

   assign m_rd           = ex_q.rd;
   assign m_reg_write_en = ex_q.reg_write_en && !stall;
   assign m_wb_data      = (ex_q.reg_write_src && read_done) ? mem_rdata : ex_q.alu_result;

   assign branch_taken  = ex_q.branch && cond_met && !stall;
   assign branch_target = ex_q.alu_result;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;

   logic        clk;
   logic        rst_n;
   logic [15:0] e_alu_result;
   logic [2:0]  e_flags;
   logic [3:0]  e_rd;
   logic [15:0] e_reg_rt;
   logic        e_mem_read_en;
   logic        e_mem_write_en;
   logic        e_reg_write_en;
   logic        e_reg_write_src;
   logic [2:0]  e_branch_cond;
   logic        e_branch;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [3:0]  m_rd;
   logic        m_reg_write_en;
   logic [15:0] m_wb_data;

   int vectors;
   int miscompares;

   memory_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .e_alu_result    (e_alu_result),
      .e_flags         (e_flags),
      .e_rd            (e_rd),
      .e_reg_rt        (e_reg_rt),
      .e_mem_read_en   (e_mem_read_en),
      .e_mem_write_en  (e_mem_write_en),
      .e_reg_write_en  (e_reg_write_en),
      .e_reg_write_src (e_reg_write_src),
      .e_branch_cond   (e_branch_cond),
      .e_branch        (e_branch),
      .mem_rdata       (mem_rdata),
      .mem_ack         (mem_ack),
      .mem_req         (mem_req),
      .mem_wr          (mem_wr),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .stall           (stall),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .m_rd            (m_rd),
      .m_reg_write_en  (m_reg_write_en),
      .m_wb_data       (m_wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_bubble();
      e_alu_result    = '0;
      e_flags         = '0;
      e_rd            = '0;
      e_reg_rt        = '0;
      e_mem_read_en   = 1'b0;
      e_mem_write_en  = 1'b0;
      e_reg_write_en  = 1'b0;
      e_reg_write_src = 1'b0;
      e_branch_cond   = '0;
      e_branch        = 1'b0;
   endtask

   task automatic drive_op(input logic rd_en, input logic wr_en, input logic rwe,
                           input logic src, input logic br, input logic [2:0] cond,
                           input logic [2:0] flags, input logic [3:0] rd,
                           input logic [15:0] alu, input logic [15:0] rt);
      e_mem_read_en   = rd_en;
      e_mem_write_en  = wr_en;
      e_reg_write_en  = rwe;
      e_reg_write_src = src;
      e_branch        = br;
      e_branch_cond   = cond;
      e_flags         = flags;
      e_rd            = rd;
      e_alu_result    = alu;
      e_reg_rt        = rt;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_bubble();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      #1;
      vectors++;
      if ({mem_req, stall, branch_taken, m_reg_write_en} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, stall, branch_taken, m_reg_write_en});
      end
      vectors++;
      if (m_wb_data !== 16'h0000 || m_rd !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_data: got wb=%h rd=%h expected 0000/0", m_wb_data, m_rd);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_req: got %b expected 0", mem_req);
      end
   endtask

   task automatic test_load_zero_wait();
      drive_op(1, 0, 1, 1, 0, 3'b000, 3'b000, 4'd3, 16'h0040, 16'h0000);
      @(posedge clk); #1;
      set_bubble();
      mem_ack   = 1'b1;
      mem_rdata = 16'h1234;
      #1;
      vectors++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0040) begin
         miscompares++;
         $display("FAIL load0_req: got req=%b wr=%b addr=%h expected 1/0/0040", mem_req, mem_wr, mem_addr);
      end
      vectors++;
      if (stall !== 1'b0 || m_reg_write_en !== 1'b1 || m_rd !== 4'd3) begin
         miscompares++;
         $display("FAIL load0_ctrl: got stall=%b we=%b rd=%h expected 0/1/3", stall, m_reg_write_en, m_rd);
      end
      vectors++;
      if (m_wb_data !== 16'h1234) begin
         miscompares++;
         $display("FAIL load0_wb: got %h expected 1234", m_wb_data);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (mem_req !== 1'b0 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL load0_after: got req=%b stall=%b expected 0/0", mem_req, stall);
      end
   endtask

   task automatic test_store_wait();
      drive_op(0, 1, 0, 0, 0, 3'b000, 3'b000, 4'd0, 16'h0010, 16'hBEEF);
      @(posedge clk); #1;
      set_bubble();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (stall !== 1'b1 || mem_req !== 1'b1 || mem_wr !== 1'b1 || m_reg_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL store_wait_ctrl[%0d]: got stall=%b req=%b wr=%b we=%b expected 1/1/1/0",
                     i, stall, mem_req, mem_wr, m_reg_write_en);
         end
         vectors++;
         if (mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL store_wait_hold[%0d]: got addr=%h wdata=%h expected 0010/BEEF", i, mem_addr, mem_wdata);
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b1;
      #1;
      vectors++;
      if (stall !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0010) begin
         miscompares++;
         $display("FAIL store_ack: got stall=%b req=%b addr=%h expected 0/1/0010", stall, mem_req, mem_addr);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL store_done: got req=%b expected 0", mem_req);
      end
   endtask

   task automatic test_load_wait();
      drive_op(1, 0, 1, 1, 0, 3'b000, 3'b000, 4'd7, 16'h0080, 16'h0000);
      @(posedge clk); #1;
      set_bubble();
      mem_ack   = 1'b0;
      mem_rdata = 16'hAAAA;
      #1;
      vectors++;
      if (stall !== 1'b1 || m_reg_write_en !== 1'b0) begin
         miscompares++;
         $display("FAIL loadw_stall: got stall=%b we=%b expected 1/0", stall, m_reg_write_en);
      end
      @(posedge clk); #1;
      mem_ack   = 1'b1;
      mem_rdata = 16'h5A5A;
      #1;
      vectors++;
      if (m_reg_write_en !== 1'b1 || m_wb_data !== 16'h5A5A || m_rd !== 4'd7) begin
         miscompares++;
         $display("FAIL loadw_done: got we=%b wb=%h rd=%h expected 1/5A5A/7", m_reg_write_en, m_wb_data, m_rd);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic test_branch();
      // {branch, cond, flags{N,Z,V}, expected taken}
      logic [7:0] tbl [16] = '{
         {1'b1, 3'b001, 3'b010, 1'b1}, {1'b1, 3'b001, 3'b000, 1'b0},
         {1'b1, 3'b000, 3'b000, 1'b1}, {1'b1, 3'b000, 3'b010, 1'b0},
         {1'b1, 3'b010, 3'b000, 1'b1}, {1'b1, 3'b010, 3'b100, 1'b0},
         {1'b1, 3'b011, 3'b100, 1'b1}, {1'b1, 3'b011, 3'b000, 1'b0},
         {1'b1, 3'b100, 3'b010, 1'b1}, {1'b1, 3'b100, 3'b100, 1'b0},
         {1'b1, 3'b101, 3'b010, 1'b1}, {1'b1, 3'b101, 3'b000, 1'b0},
         {1'b1, 3'b110, 3'b001, 1'b1}, {1'b1, 3'b110, 3'b110, 1'b0},
         {1'b1, 3'b111, 3'b000, 1'b1}, {1'b0, 3'b111, 3'b000, 1'b0}
      };
      for (int i = 0; i < 16; i++) begin
         logic [7:0]  v;
         logic [15:0] tgt;
         v   = tbl[i];
         tgt = 16'h0100 + 16'(i);
         drive_op(0, 0, 0, 0, v[7], v[6:4], v[3:1], 4'd0, tgt, 16'h0000);
         @(posedge clk); #1;
         vectors++;
         if (branch_taken !== v[0] || branch_target !== tgt) begin
            miscompares++;
            $display("FAIL branch[%0d] cond=%b flags=%b: got taken=%b tgt=%h expected %b/%h",
                     i, v[6:4], v[3:1], branch_taken, branch_target, v[0], tgt);
         end
      end
      set_bubble();
      @(posedge clk); #1;
   endtask

   task automatic test_branch_with_mem();
      drive_op(1, 0, 0, 0, 1, 3'b111, 3'b000, 4'd0, 16'h0300, 16'h0000);
      @(posedge clk); #1;
      set_bubble();
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (branch_taken !== 1'b0 || stall !== 1'b1) begin
         miscompares++;
         $display("FAIL brmem_wait: got taken=%b stall=%b expected 0/1", branch_taken, stall);
      end
      @(posedge clk); #1;
      mem_ack = 1'b1;
      #1;
      vectors++;
      if (branch_taken !== 1'b1 || branch_target !== 16'h0300) begin
         miscompares++;
         $display("FAIL brmem_done: got taken=%b tgt=%h expected 1/0300", branch_taken, branch_target);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      drive_op(1, 0, 1, 0, 1, 3'b111, 3'b000, 4'd2, 16'h0060, 16'h0000);
      @(posedge clk); #1;
      set_bubble();
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL rstw_pre: got stall=%b expected 1", stall);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({mem_req, stall, branch_taken, m_reg_write_en} !== 4'b0000) begin
         miscompares++;
         $display("FAIL rstw_during: got %b expected 0000", {mem_req, stall, branch_taken, m_reg_write_en});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (mem_req !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rstw_after[%0d]: got req=%b stall=%b expected 0/0", i, mem_req, stall);
         end
      end
      drive_op(1, 0, 0, 0, 0, 3'b000, 3'b000, 4'd0, 16'h0070, 16'h0000);
      @(posedge clk); #1;
      set_bubble();
      mem_ack = 1'b1;
      #1;
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0070) begin
         miscompares++;
         $display("FAIL rstw_newop: got req=%b addr=%h expected 1/0070", mem_req, mem_addr);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic test_read_write_both();
      drive_op(1, 1, 1, 1, 0, 3'b000, 3'b000, 4'd9, 16'h0222, 16'h3333);
      @(posedge clk); #1;
      set_bubble();
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      #1;
      vectors++;
      if (mem_wr !== 1'b1 || mem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL rw_wr: got wr=%b req=%b expected 1/1", mem_wr, mem_req);
      end
      vectors++;
      if (m_wb_data !== 16'h0222 || m_reg_write_en !== 1'b1) begin
         miscompares++;
         $display("FAIL rw_wb: got wb=%h we=%b expected 0222/1", m_wb_data, m_reg_write_en);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic test_ignore_ack();
      drive_op(0, 0, 1, 0, 0, 3'b000, 3'b000, 4'd5, 16'h5555, 16'h0000);
      @(posedge clk); #1;
      set_bubble();
      mem_ack   = 1'b1;
      mem_rdata = 16'hFFFF;
      #1;
      vectors++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || m_wb_data !== 16'h5555 || m_reg_write_en !== 1'b1) begin
         miscompares++;
         $display("FAIL ack_noreq: got req=%b stall=%b wb=%h we=%b expected 0/0/5555/1",
                  mem_req, stall, m_wb_data, m_reg_write_en);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      drive_op(0, 1, 0, 0, 0, 3'b000, 3'b000, 4'd0, 16'h0020, 16'h1111);
      @(posedge clk); #1;
      set_bubble();
      #1;
      vectors++;
      if (stall !== 1'b1 || mem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL ack_noreq_next: got stall=%b req=%b expected 1/1", stall, mem_req);
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_load_zero_wait();
      test_store_wait();
      test_load_wait();
      test_branch();
      test_branch_with_mem();
      test_reset_in_wait();
      test_read_write_both();
      test_ignore_ack();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
